// File: rtl/results_conv_seq_if.sv
// Producer handshake and results_conv write bus for results_conv_seq.
// slave is the sequencer's view; master is the producer/converter side.
interface results_conv_seq_if;
  logic        s0_valid;
  logic [15:0] s0_data;
  logic        s0_ready;
  logic        s1_valid;
  logic [15:0] s1_data;
  logic        s1_ready;
  logic [3:0]  address;
  logic [15:0] din;
  logic        din_oe;
  logic        rcc_clk;
  logic        grant_id;
  logic        busy;
  logic        frame_done;

  modport slave (
    input  s0_valid, s0_data, s1_valid, s1_data,
    output s0_ready, s1_ready, address, din, din_oe, rcc_clk,
           grant_id, busy, frame_done
  );

  modport master (
    output s0_valid, s0_data, s1_valid, s1_data,
    input  s0_ready, s1_ready, address, din, din_oe, rcc_clk,
           grant_id, busy, frame_done
  );
endinterface

// File: rtl/results_conv_seq.sv
// Round-robin frame sequencer writing NUM_WORDS words into results_conv with a post-frame gap.
// Define RESULTS_CONV_SEQ_IDLE_WAIT_EN to add conv_idle, which stretches the gap until the converter is idle.
module results_conv_seq #(
  parameter int NUM_WORDS  = 9,
  parameter int GAP_CYCLES = 160,
  parameter int GAP_W      = 16
) (
  input logic clk,
  input logic reset,
`ifdef RESULTS_CONV_SEQ_IDLE_WAIT_EN
  input logic conv_idle,
`endif
  results_conv_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, FETCH, SETUP, HIGH, LOW, GAP} state_t;

  localparam logic [3:0]       LAST_WORD = 4'(NUM_WORDS - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);

  state_t state, next_state;

  logic [3:0]       word_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             grant_id;
  logic             last_grant;
  logic [3:0]       address;
  logic [15:0]      din;
  logic             din_oe;
  logic             rcc_clk;
  logic             frame_done;

  logic             any_valid;
  logic             pick;
  logic             sel_valid;
  logic [15:0]      sel_data;
  logic             last_word;
  logic             gap_exit;

  // On a tie the requester that did not own the previous frame wins.
  assign any_valid = bus.s0_valid | bus.s1_valid;
  assign pick      = (bus.s0_valid && bus.s1_valid) ? ~last_grant : bus.s1_valid;
  assign sel_valid = grant_id ? bus.s1_valid : bus.s0_valid;
  assign sel_data  = grant_id ? bus.s1_data  : bus.s0_data;
  assign last_word = (word_cnt == LAST_WORD);

`ifdef RESULTS_CONV_SEQ_IDLE_WAIT_EN
  assign gap_exit = (gap_cnt == '0) && conv_idle;
`else
  assign gap_exit = (gap_cnt == '0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_valid) next_state = FETCH;
      FETCH:   if (sel_valid) next_state = SETUP;
      SETUP:   next_state = HIGH;
      HIGH:    next_state = LOW;
      LOW:     next_state = last_word ? GAP : FETCH;
      GAP:     if (gap_exit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: din/address launch on the handshake, strobe one cycle later, hold one cycle after.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt   <= '0;
      gap_cnt    <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      address    <= '0;
      din        <= '0;
      din_oe     <= 1'b0;
      rcc_clk    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id   <= pick;
            last_grant <= pick;
            word_cnt   <= '0;
          end
        end
        FETCH: begin
          if (sel_valid) begin
            din     <= sel_data;
            address <= word_cnt;
            din_oe  <= 1'b1;
          end
        end
        SETUP: rcc_clk <= 1'b1;
        HIGH:  rcc_clk <= 1'b0;
        LOW: begin
          din_oe <= 1'b0;
          din    <= '0;
          if (last_word) begin
            frame_done <= 1'b1;
            gap_cnt    <= GAP_LOAD;
          end else begin
            word_cnt <= word_cnt + 4'd1;
          end
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.s0_ready   = (state == FETCH) && !grant_id;
  assign bus.s1_ready   = (state == FETCH) &&  grant_id;
  assign bus.address    = address;
  assign bus.din        = din;
  assign bus.din_oe     = din_oe;
  assign bus.rcc_clk    = rcc_clk;
  assign bus.grant_id   = grant_id;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_results_conv_seq.sv
// Directed bench for results_conv_seq: default-size instance (a) and a 1-word/1-gap instance (b).
module tb_results_conv_seq;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  results_conv_seq_if a_if ();
  results_conv_seq_if b_if ();

`ifdef RESULTS_CONV_SEQ_IDLE_WAIT_EN
  logic conv_idle_a;
  logic conv_idle_b;
`endif

  results_conv_seq #(.NUM_WORDS(9), .GAP_CYCLES(160), .GAP_W(16)) dut_a (
    .clk       (clk),
    .reset     (reset),
`ifdef RESULTS_CONV_SEQ_IDLE_WAIT_EN
    .conv_idle (conv_idle_a),
`endif
    .bus       (a_if.slave)
  );

  results_conv_seq #(.NUM_WORDS(1), .GAP_CYCLES(1), .GAP_W(16)) dut_b (
    .clk       (clk),
    .reset     (reset),
`ifdef RESULTS_CONV_SEQ_IDLE_WAIT_EN
    .conv_idle (conv_idle_b),
`endif
    .bus       (b_if.slave)
  );

  task automatic do_reset();
    reset = 1'b1;
    a_if.s0_valid = 1'b0; a_if.s0_data = '0; a_if.s1_valid = 1'b0; a_if.s1_data = '0;
    b_if.s0_valid = 1'b0; b_if.s0_data = '0; b_if.s1_valid = 1'b0; b_if.s1_data = '0;
`ifdef RESULTS_CONV_SEQ_IDLE_WAIT_EN
    conv_idle_a = 1'b1;
    conv_idle_b = 1'b1;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int  k;
    logic pending, found, prev_rcc;
    do_reset();
    checks++;
    if (a_if.address !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_address: got %0h expected 0", a_if.address);
    end
    checks++;
    if (a_if.din !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_din: got %0h expected 0", a_if.din);
    end
    checks++;
    if ({a_if.din_oe, a_if.rcc_clk, a_if.grant_id, a_if.busy, a_if.frame_done,
         a_if.s0_ready, a_if.s1_ready} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 0000000",
               {a_if.din_oe, a_if.rcc_clk, a_if.grant_id, a_if.busy, a_if.frame_done,
                a_if.s0_ready, a_if.s1_ready});
    end

    // Run a frame until word 3's strobe is high, then reset in the middle of HIGH.
    a_if.s0_valid = 1'b1; a_if.s1_valid = 1'b1;
    a_if.s0_data = 16'h0200; a_if.s1_data = 16'h0BBB;
    k = 0; pending = 1'b0; found = 1'b0;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      @(negedge clk);
      if (pending) begin pending = 1'b0; k++; a_if.s0_data = 16'h0200 + 16'(k); end
      if (a_if.rcc_clk && a_if.address == 4'd3) found = 1'b1;
      if (a_if.s0_valid && a_if.s0_ready) pending = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("[TB] FAIL reset_reach_word3: got timeout expected strobe at address 3");
    end
    reset = 1'b1;
    #1;
    checks++;
    if (a_if.rcc_clk !== 1'b0) begin
      errors++; $display("[TB] FAIL midframe_rcc_clk: got %b expected 0", a_if.rcc_clk);
    end
    checks++;
    if (a_if.din_oe !== 1'b0) begin
      errors++; $display("[TB] FAIL midframe_din_oe: got %b expected 0", a_if.din_oe);
    end
    checks++;
    if (a_if.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midframe_busy: got %b expected 0", a_if.busy);
    end
    a_if.s0_data = 16'h0200;
    @(negedge clk);
    reset = 1'b0;
    found = 1'b0; prev_rcc = 1'b0;
    for (int cyc = 0; cyc < 50 && !found; cyc++) begin
      @(negedge clk);
      if (a_if.rcc_clk && !prev_rcc) begin
        found = 1'b1;
        checks++;
        if (a_if.address !== 4'd0 || a_if.din !== 16'h0200 || a_if.grant_id !== 1'b0) begin
          errors++;
          $display("[TB] FAIL restart_first_word: got addr=%0h din=%0h grant=%b expected addr=0 din=0200 grant=0",
                   a_if.address, a_if.din, a_if.grant_id);
        end
      end
      prev_rcc = a_if.rcc_clk;
    end
    checks++;
    if (!found) begin
      errors++; $display("[TB] FAIL restart_timeout: got no strobe expected strobe after reset");
    end
  endtask

  task automatic test_single_frame();
    int k, rises, last_rise, oe_cycles, done_pulses, done_cycle, wide;
    logic pending, prev_rcc, finished;
    do_reset();
    a_if.s0_data = 16'h0001; a_if.s0_valid = 1'b1;
    k = 0; rises = 0; last_rise = 0; oe_cycles = 0; done_pulses = 0; done_cycle = -1; wide = 0;
    pending = 1'b0; prev_rcc = 1'b0; finished = 1'b0;
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      @(negedge clk);
      if (pending) begin
        pending = 1'b0; k++;
        if (k < 9) a_if.s0_data = 16'(k + 1);
        else       a_if.s0_valid = 1'b0;
      end
      if (a_if.rcc_clk && !prev_rcc) begin
        checks++;
        if (a_if.address !== 4'(rises) || a_if.din !== 16'(rises + 1)) begin
          errors++;
          $display("[TB] FAIL frame_word%0d: got addr=%0h din=%0h expected addr=%0h din=%0h",
                   rises, a_if.address, a_if.din, rises, rises + 1);
        end
        if (rises > 0) begin
          checks++;
          if (cyc - last_rise != 4) begin
            errors++; $display("[TB] FAIL frame_spacing%0d: got %0d expected 4", rises, cyc - last_rise);
          end
        end
        last_rise = cyc; rises++;
      end
      if (a_if.rcc_clk && prev_rcc) wide++;
      prev_rcc = a_if.rcc_clk;
      if (a_if.din_oe) oe_cycles++;
      if (a_if.frame_done) begin done_pulses++; done_cycle = cyc; end
      if (done_cycle >= 0 && !a_if.busy) begin
        finished = 1'b1;
        checks++;
        if (cyc - done_cycle != 160) begin
          errors++; $display("[TB] FAIL gap_length: got %0d expected 160", cyc - done_cycle);
        end
      end
      if (a_if.s0_valid && a_if.s0_ready) pending = 1'b1;
    end
    checks++;
    if (rises != 9) begin errors++; $display("[TB] FAIL frame_strobes: got %0d expected 9", rises); end
    checks++;
    if (wide != 0) begin errors++; $display("[TB] FAIL strobe_width: got %0d wide cycles expected 0", wide); end
    checks++;
    if (oe_cycles != 27) begin errors++; $display("[TB] FAIL din_oe_cycles: got %0d expected 27", oe_cycles); end
    checks++;
    if (done_pulses != 1) begin errors++; $display("[TB] FAIL frame_done_pulses: got %0d expected 1", done_pulses); end
    checks++;
    if (!finished) begin errors++; $display("[TB] FAIL busy_release: got timeout expected busy low"); end
  endtask

  task automatic test_round_robin();
    int frames, dones, leak, bad_din;
    logic prev_busy, prev_rcc, exp_g;
    do_reset();
    a_if.s0_valid = 1'b1; a_if.s1_valid = 1'b1;
    a_if.s0_data = 16'hA0A0; a_if.s1_data = 16'hB1B1;
    frames = 0; dones = 0; leak = 0; bad_din = 0; prev_busy = 1'b0; prev_rcc = 1'b0; exp_g = 1'b0;
    for (int cyc = 0; cyc < 900 && dones < 3; cyc++) begin
      @(negedge clk);
      if (a_if.busy && !prev_busy) begin
        exp_g = frames[0];
        checks++;
        if (a_if.grant_id !== exp_g) begin
          errors++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", frames, a_if.grant_id, exp_g);
        end
        frames++;
      end
      if (a_if.busy && frames > 0) begin
        if (exp_g ? a_if.s0_ready : a_if.s1_ready) leak++;
        if (a_if.rcc_clk && !prev_rcc && a_if.din !== (exp_g ? 16'hB1B1 : 16'hA0A0)) bad_din++;
      end
      if (a_if.frame_done) dones++;
      prev_busy = a_if.busy;
      prev_rcc = a_if.rcc_clk;
    end
    checks++;
    if (dones != 3) begin errors++; $display("[TB] FAIL rr_frames: got %0d expected 3", dones); end
    checks++;
    if (leak != 0) begin errors++; $display("[TB] FAIL rr_other_ready: got %0d cycles expected 0", leak); end
    checks++;
    if (bad_din != 0) begin errors++; $display("[TB] FAIL rr_data: got %0d bad words expected 0", bad_din); end
  endtask

  task automatic test_stall();
    int k, rises, rise4, stall_left, quiet_bad, grant_bad;
    logic pending, prev_rcc, done;
    do_reset();
    a_if.s1_valid = 1'b1; a_if.s1_data = 16'hDEAD;
    a_if.s0_valid = 1'b1; a_if.s0_data = 16'h0100;
    k = 0; rises = 0; rise4 = 0; stall_left = 0; quiet_bad = 0; grant_bad = 0;
    pending = 1'b0; prev_rcc = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      if (stall_left > 0) begin
        if (stall_left <= 8 && (a_if.rcc_clk || a_if.din_oe)) quiet_bad++;
        stall_left--;
        if (stall_left == 0) a_if.s0_valid = 1'b1;
      end
      if (pending) begin
        pending = 1'b0; k++;
        a_if.s0_data = 16'h0100 + 16'(k);
        if (k == 5) begin a_if.s0_valid = 1'b0; stall_left = 10; end
        else if (k == 9) a_if.s0_valid = 1'b0;
      end
      if (a_if.busy && (a_if.grant_id !== 1'b0 || a_if.s1_ready)) grant_bad++;
      if (a_if.rcc_clk && !prev_rcc) begin
        if (rises == 4) rise4 = cyc;
        if (rises == 5) begin
          checks++;
          if (a_if.address !== 4'd5 || a_if.din !== 16'h0105) begin
            errors++;
            $display("[TB] FAIL stall_word5: got addr=%0h din=%0h expected addr=5 din=0105",
                     a_if.address, a_if.din);
          end
          checks++;
          if (cyc - rise4 != 11) begin
            errors++; $display("[TB] FAIL stall_delay: got %0d expected 11", cyc - rise4);
          end
        end
        rises++;
      end
      prev_rcc = a_if.rcc_clk;
      if (a_if.frame_done) done = 1'b1;
      if (a_if.s0_valid && a_if.s0_ready) pending = 1'b1;
    end
    checks++;
    if (!done || rises != 9) begin
      errors++; $display("[TB] FAIL stall_frame: got done=%b strobes=%0d expected done=1 strobes=9", done, rises);
    end
    checks++;
    if (quiet_bad != 0) begin errors++; $display("[TB] FAIL stall_quiet: got %0d active cycles expected 0", quiet_bad); end
    checks++;
    if (grant_bad != 0) begin errors++; $display("[TB] FAIL stall_grant: got %0d s1 cycles expected 0", grant_bad); end
  endtask

  task automatic test_one_word();
    int rises, last_rise, dones, gap_bad, word_bad;
    logic prev_rcc;
    do_reset();
    b_if.s0_valid = 1'b1; b_if.s0_data = 16'hCAFE;
    rises = 0; last_rise = 0; dones = 0; gap_bad = 0; word_bad = 0; prev_rcc = 1'b0;
    for (int cyc = 0; cyc < 100 && rises < 8; cyc++) begin
      @(negedge clk);
      if (b_if.frame_done) dones++;
      if (b_if.rcc_clk && !prev_rcc) begin
        if (b_if.address !== 4'd0 || b_if.din !== 16'hCAFE || b_if.grant_id !== 1'b0) word_bad++;
        if (rises > 0 && cyc - last_rise != 6) gap_bad++;
        last_rise = cyc; rises++;
      end
      prev_rcc = b_if.rcc_clk;
    end
    checks++;
    if (rises != 8) begin errors++; $display("[TB] FAIL one_word_strobes: got %0d expected 8", rises); end
    checks++;
    if (gap_bad != 0) begin errors++; $display("[TB] FAIL one_word_period: got %0d bad gaps expected 0", gap_bad); end
    checks++;
    if (word_bad != 0) begin errors++; $display("[TB] FAIL one_word_data: got %0d bad words expected 0", word_bad); end
    checks++;
    if (dones != 7) begin errors++; $display("[TB] FAIL one_word_done: got %0d expected 7", dones); end
  endtask

`ifdef RESULTS_CONV_SEQ_IDLE_WAIT_EN
  task automatic test_idle_wait();
    int early;
    logic seen;
    do_reset();
    conv_idle_a = 1'b0;
    a_if.s0_valid = 1'b1; a_if.s0_data = 16'h0300;
    seen = 1'b0; early = 0;
    for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
      @(negedge clk);
      if (a_if.frame_done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL idle_wait_frame: got timeout expected frame_done"); end
    for (int i = 1; i <= 210; i++) begin
      @(negedge clk);
      if (!a_if.busy) early++;
    end
    conv_idle_a = 1'b1;
    checks++;
    if (early != 0) begin errors++; $display("[TB] FAIL idle_wait_hold: got %0d idle cycles expected 0", early); end
    @(negedge clk);
    checks++;
    if (a_if.busy !== 1'b0 || a_if.s0_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_wait_idle: got busy=%b ready=%b expected 0 0", a_if.busy, a_if.s0_ready);
    end
    @(negedge clk);
    checks++;
    if (a_if.s0_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL idle_wait_fetch: got ready=%b expected 1", a_if.s0_ready);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_stall();
    test_one_word();
`ifdef RESULTS_CONV_SEQ_IDLE_WAIT_EN
    test_idle_wait();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
